// File: rtl/maj3_filter_pkg.sv
// rtl/maj3_filter_pkg.sv - shared constants and helpers for the majority-vote pin filters
package maj3_filter_pkg;

  localparam int   DIV_W_DEF    = 8;
  localparam int   GCNT_W_DEF   = 8;
  localparam logic IDLE_LVL_DEF = 1'b1;

  localparam logic [2:0] GLITCH_010 = 3'b010;
  localparam logic [2:0] GLITCH_101 = 3'b101;

  // An isolated single-sample excursion shows up as an alternating 3-sample window.
  function automatic logic is_glitch(input logic [2:0] h);
    return (h == GLITCH_010) || (h == GLITCH_101);
  endfunction

endpackage

// File: rtl/generic__maj3.sv
// rtl/generic__maj3.sv - 3-input combinational majority gate
module generic__maj3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/maj3_tick_gen.sv
// rtl/maj3_tick_gen.sv - reloadable prescaler producing a sample strobe every div+1 cycles
module maj3_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // div is only sampled at reload, so a running period is never cut short.
  always_comb begin
    cnt_d = cnt_q;
    tick  = enable && (cnt_q == '0);
    if (!enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = div;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/maj3_sample_filter.sv
// rtl/maj3_sample_filter.sv - synchronise, prescale-sample and majority-filter one pad input
import maj3_filter_pkg::*;

module maj3_sample_filter #(
  parameter int   DIV_W    = DIV_W_DEF,
  parameter int   GCNT_W   = GCNT_W_DEF,
  parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div,
  input  logic              din,
  input  logic              glitch_clr,
  output logic              dout,
  output logic              rise,
  output logic              fall,
  output logic              tick,
  output logic [GCNT_W-1:0] glitch_cnt
);

  logic              sync1_q, sync2_q;
  logic [2:0]        hist_q, hist_d;
  logic              dout_q, rise_q, fall_q, tick_q;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              tick_int;
  logic              vote;
  logic [2:0]        hist_next;

  maj3_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .div    (div),
    .tick   (tick_int)
  );

  generic__maj3 u_maj3 (
    .a (hist_q[0]),
    .b (hist_q[1]),
    .c (hist_q[2]),
    .y (vote)
  );

  assign hist_next = {hist_q[1:0], sync2_q};

  always_comb begin
    hist_d = hist_q;
    gcnt_d = gcnt_q;
    if (tick_int) begin
      hist_d = hist_next;
    end
    // Clear takes priority over a same-cycle glitch; the count sticks at all-ones.
    if (glitch_clr) begin
      gcnt_d = '0;
    end else if (tick_int && is_glitch(hist_next) && (gcnt_q != {GCNT_W{1'b1}})) begin
      gcnt_d = gcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      hist_q  <= {3{IDLE_LVL}};
      dout_q  <= IDLE_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      tick_q  <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      dout_q  <= vote;
      rise_q  <= vote & ~dout_q;
      fall_q  <= ~vote & dout_q;
      tick_q  <= tick_int;
      gcnt_q  <= gcnt_d;
    end
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign tick       = tick_q;
  assign glitch_cnt = gcnt_q;

endmodule

// File: tb/tb_maj3_sample_filter.sv
// tb/tb_maj3_sample_filter.sv - directed self-checking bench for maj3_sample_filter
module tb_maj3_sample_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] div;
  logic       din;
  logic       glitch_clr;
  logic       dout, rise, fall, tick;
  logic [7:0] glitch_cnt;

  int passes = 0;
  int total  = 0;

  maj3_sample_filter #(.DIV_W(8), .GCNT_W(8), .IDLE_LVL(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .div        (div),
    .din        (din),
    .glitch_clr (glitch_clr),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .tick       (tick),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the registered tick strobe is seen; gives up after 40 cycles.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 40);
  endtask

  // One-sample low excursion aligned to a tick; optionally clears on the glitch tick.
  task automatic glitch_pulse(input bit clr_at, output bit bad_dout, output bit tick_at_glitch);
    int n;
    bad_dout = 1'b0;
    wait_tick(n);
    if (n >= 40) bad_dout = 1'b1;
    din = 1'b0;
    repeat (4) begin step(); if (dout !== 1'b1) bad_dout = 1'b1; end
    din = 1'b1;
    repeat (3) begin step(); if (dout !== 1'b1) bad_dout = 1'b1; end
    if (clr_at) glitch_clr = 1'b1;
    step();
    tick_at_glitch = tick;
    glitch_clr = 1'b0;
    repeat (8) begin step(); if (dout !== 1'b1) bad_dout = 1'b1; end
  endtask

  initial begin
    int  n;
    bit  flag, bad, tk;

    rst_n = 1'b0; enable = 1'b0; div = 8'd0; din = 1'b0; glitch_clr = 1'b0;
    repeat (3) step();
    check("rst_dout", dout, 1);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_tick", tick, 0);
    check("rst_gcnt", glitch_cnt, 0);

    rst_n = 1'b1; enable = 1'b1; din = 1'b1;
    step();
    check("first_tick", tick, 1);
    flag = 1'b0;
    repeat (8) begin step(); if (dout !== 1'b1 || rise || fall) flag = 1'b1; end
    check("idle_quiet", flag, 0);

    // Clean falling step: five flop stages to dout.
    din = 1'b0;
    repeat (4) step();
    check("lat_dout_before", dout, 1);
    check("lat_fall_before", fall, 0);
    step();
    check("lat_dout_at5", dout, 0);
    check("lat_fall_at5", fall, 1);
    step();
    check("lat_fall_1cyc", fall, 0);
    check("lat_gcnt", glitch_cnt, 0);
    din = 1'b1;
    repeat (4) step();
    check("rise_before", rise, 0);
    step();
    check("rise_at5", rise, 1);
    check("rise_dout", dout, 1);

    // Prescaler: div=4 gives period 5; reload to 1 applies only after the current period.
    div = 8'd4;
    wait_tick(n);
    wait_tick(n);
    check("div4_period", n, 5);
    step();
    div = 8'd1;
    n = 1;
    do begin step(); n++; end while (!tick && n < 40);
    check("div_change_cur", n, 5);
    wait_tick(n);
    check("div1_period", n, 2);
    wait_tick(n);
    check("div1_period2", n, 2);

    enable = 1'b0;
    flag = 1'b0;
    repeat (10) begin step(); if (tick) flag = 1'b1; end
    check("disabled_no_tick", flag, 0);
    enable = 1'b1;
    step();
    check("reenable_tick", tick, 1);

    // Glitch rejection and clear priority at div=3.
    div = 8'd3;
    repeat (6) step();
    glitch_pulse(1'b0, bad, tk);
    check("glitch1_dout", bad, 0);
    check("glitch1_cnt", glitch_cnt, 1);
    check("glitch1_tick_align", tk, 1);
    repeat (6) glitch_pulse(1'b0, bad, tk);
    check("glitch7_cnt", glitch_cnt, 7);
    glitch_pulse(1'b1, bad, tk);
    check("clr_tick_align", tk, 1);
    check("clr_priority", glitch_cnt, 0);

    flag = 1'b0;
    for (int i = 0; i < 300; i++) begin
      glitch_pulse(1'b0, bad, tk);
      if (bad) flag = 1'b1;
    end
    check("sat_dout_stable", flag, 0);
    check("sat_cnt", glitch_cnt, 255);

    // Async reset with dout=0 and history 001.
    div = 8'd0;
    din = 1'b0;
    repeat (10) step();
    check("pre_rst_dout", dout, 0);
    din = 1'b1;
    repeat (3) step();
    check("pre_rst_hist001_dout", dout, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", dout, 1);
    check("async_rst_gcnt", glitch_cnt, 0);
    check("async_rst_tick", tick, 0);
    din = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_edge1_dout", dout, 1);
    repeat (3) step();
    check("post_rst_edge4_dout", dout, 1);
    step();
    check("post_rst_edge5_fall", fall, 1);
    check("post_rst_edge5_dout", dout, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/maj3_sample_filter.md
Name: maj3_sample_filter

Overview:
- Input conditioner for the I2C pins (SCL/SDA) of the BERT design.
- Synchronises an asynchronous pin and samples it at a programmable prescaled rate into a 3-deep history.
- Majority-votes the history through one generic__maj3 instance.
- Emits a filtered level, one-cycle rise/fall strobes and a saturating count of isolated glitches for the BERT error statistics.
- One instance per pin, between the pad inputs and the I2C protocol engine.

Parameters:
- DIV_W, 8, width of prescaler reload value.
- GCNT_W, 8, width of glitch counter.
- IDLE_LVL, 1'b1, reset/idle level of sync flops, history and dout (I2C idle-high).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  sampling enable
- div  in  DIV_W  prescaler reload; sample tick every div+1 cycles
- din  in  1  raw asynchronous pin input
- glitch_clr  in  1  synchronous clear of glitch_cnt
- dout  out  1  filtered level (registered)
- rise  out  1  one-cycle pulse, dout 0->1
- fall  out  1  one-cycle pulse, dout 1->0
- tick  out  1  sample strobe (registered), for debug/BERT alignment
- glitch_cnt  out  GCNT_W  saturating count of isolated glitches

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - sync1, sync2, hist[2:0] and dout = IDLE_LVL.
  - rise, fall, tick = 0.
  - Prescaler count = 0, glitch_cnt = 0.
- Synchroniser: 2 flops (din->sync1->sync2). Always runs regardless of enable.
- Prescaler:
  - tick_int = enable & (cnt==0).
  - On tick_int, cnt <= div; else if cnt!=0, cnt <= cnt-1.
  - enable=0 forces cnt <= 0, so the first tick occurs in the first cycle enable is high.
  - div changes take effect at the next reload only; an in-progress count is never truncated.
  - div=0 gives a tick every cycle.
- History: on tick_int, hist <= {hist[1:0], sync2}. Otherwise hold.
- Vote: X = maj3(hist[0], hist[1], hist[2]), combinational via generic__maj3.
- Output register, each cycle:
  - dout <= X.
  - rise <= X & ~dout.
  - fall <= ~X & dout.
  - tick <= tick_int.
- Latency: with div=0 and enable=1, a clean din step before edge 0 reaches dout at edge 5 (sync 2, history 2, output reg 1). rise/fall assert in the same cycle dout changes.
- Glitch detect: on tick_int, evaluate next history {hist[1:0],sync2}. If it equals 3'b010 or 3'b101, glitch_cnt increments.
- glitch_cnt saturation and clear:
  - Saturates at all-ones; no wrap.
  - glitch_clr=1 sets glitch_cnt to 0, and clear wins over a simultaneous increment.
- enable=0:
  - No ticks; history, dout and glitch_cnt hold.
  - rise/fall fall to 0 one cycle after the last change.
- Reset mid-operation returns everything to reset values immediately. No partial history survives.
- No combinational path from din to any output.

Decomposition:
- Package maj3_filter_pkg holds:
  - default DIV_W, GCNT_W, IDLE_LVL constants;
  - the glitch pattern constants GLITCH_010 = 3'b010 and GLITCH_101 = 3'b101.
- Sub-modules:
  - One generic__maj3 instance for the vote.
  - Prescaler as sub-module maj3_tick_gen (count/reload/enable logic), reused by other pin filters.

Test Plan:
- Reset/idle: rst_n low with din=0 -> dout=1, rise=fall=tick=0, glitch_cnt=0. Release, enable=1, div=0, din=1 held -> dout stays 1, no strobes.
- Clean step latency: div=0, din 1->0 before edge 0 -> fall=1 and dout=0 exactly at edge 5. Pulse lasts 1 cycle. glitch_cnt unchanged.
- Glitch rejection: div=3, din low for exactly one sample period (4 cycles) aligned to a tick -> dout never changes, glitch_cnt=1. Repeat 300 times with GCNT_W=8 -> glitch_cnt=255 (saturated).
- Prescaler: div=4 -> tick every 5 cycles. Change div to 1 mid-count -> current period completes at 5, subsequent periods are 2. enable low for 10 cycles -> no tick. Re-enable -> tick in first enabled cycle.
- Clear priority: glitch_cnt=7, glitch_clr asserted in the same cycle as a glitch tick -> glitch_cnt=0 next cycle.
- Async reset mid-operation: assert rst_n between clock edges while dout=0 and history=3'b001 -> dout=1 and glitch_cnt=0 immediately, with no clock edge. First post-reset tick uses a fresh history.
